// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning path:
//   - btn_state_t : 2-bit debounce FSM state encoding
//   - DEF_*       : default debounce / auto-repeat timing for a 100 MHz clock
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    // 10 ms of stability at 100 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 20;
    // 500 ms before the first repeat, then one repeat every 100 ms
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous board input.
// Ports:
//   clock    : destination clock, rising edge
//   reset    : asynchronous, active-high; both flops clear to 0
//   async_in : raw asynchronous input
//   sync_out : synchronized level (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions one raw mechanical push-button into a debounced level plus
// single-cycle press / release pulses used as counter clock-enables.
// Optional build macro: BTN_AUTOREPEAT_EN (adds auto-repeat press pulses
// while the button stays held).
// Ports:
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-high; clears all state
//   btn_in        : raw asynchronous button level, 1 = pressed
//   btn_level     : debounced registered level
//   press_pulse   : one-cycle pulse on accepted press (and on auto-repeat)
//   release_pulse : one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
            $error("button_conditioner: repeat timing must be at least 1 cycle");
        end
    endgenerate

    logic             sync_s;
    btn_state_t       state_r;
    btn_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_s;
    logic             rep_fire_s;
    logic             btn_level_r;
    logic             press_pulse_r;
    logic             release_pulse_r;

    sync_2ff u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (btn_in),
        .sync_out (sync_s)
    );

    // Debounce FSM state and stability counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE_LOW;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Debounce FSM next-state and counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_nxt_s = WAIT_HIGH;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!sync_s) begin
                    state_nxt_s = IDLE_LOW;     // bounce rejected
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = HELD_HIGH;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            HELD_HIGH: begin
                if (!sync_s) begin
                    state_nxt_s = WAIT_LOW;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = HELD_HIGH;
                end
            end
            WAIT_LOW: begin
                if (sync_s) begin
                    state_nxt_s = HELD_HIGH;    // bounce rejected
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE_LOW;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE_LOW;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // The debounced level is a pure decode of the registered state; the
    // pulses are edges of that level, detected against btn_level_r.
    assign level_s = (state_r == HELD_HIGH) || (state_r == WAIT_LOW);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_armed_r;
    logic             rep_run_s;
    logic [REP_W-1:0] rep_tgt_s;

    // Repeat timing runs only once the press has been reported and the
    // button is still seen held; any other state restarts the delay.
    always_comb begin
        rep_run_s  = (state_r == HELD_HIGH) && btn_level_r && sync_s;
        rep_tgt_s  = rep_armed_r ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
        rep_fire_s = rep_run_s && (rep_cnt_r == rep_tgt_s);
    end

    // Repeat counter and first-delay-elapsed flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt_r   <= {REP_W{1'b0}};
            rep_armed_r <= 1'b0;
        end else if (!rep_run_s) begin
            rep_cnt_r   <= {REP_W{1'b0}};
            rep_armed_r <= 1'b0;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= {REP_W{1'b0}};
            rep_armed_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_r + REP_W'(1);
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Output register layer: level and pulses change on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_level_r     <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            btn_level_r     <= level_s;
            press_pulse_r   <= (level_s && !btn_level_r) || rep_fire_s;
            release_pulse_r <= !level_s && btn_level_r;
        end
    end

    assign btn_level     = btn_level_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;

endmodule
